// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline control for the 5-stage RISC-V core. It looks at the hazard-relevant
// fields of the IF/ID, ID/EX and EX/MEM buffers and produces the hold and flush
// controls that gate those registers:
//   - load-use stall (one bubble injected into ID/EX, PC and IF/ID held)
//   - EX-stage redirect (taken branch / jump): IF/ID and ID/EX flushed
//   - data-memory request/acknowledge handshake with timeout; an outstanding
//     access or a timeout error freezes the whole pipeline
//
// Parameters
//   ACK_TIMEOUT  WAIT cycles without dmem_ack before entering ERR (1..65535)
//   CNT_W        width of the saturating stall-cycle counter
//
// Ports
//   clk             core clock, rising-edge
//   reset           synchronous, active-high
//   ifid_instr      IF/ID instruction word (rs1 = [19:15], rs2 = [24:20])
//   idex_memread    ID/EX MemRead
//   idex_rd         ID/EX destination register
//   ex_redirect     branch taken / jump resolved in EX this cycle
//   exmem_memread   EX/MEM MemRead
//   exmem_memwrite  EX/MEM MemWrite
//   dmem_ack        data memory completed the access this cycle
//   dmem_req        data memory request, held until acknowledged
//   pc_en           PC load enable
//   ifid_en         IF/ID load enable
//   ifid_flush      load a NOP into IF/ID
//   idex_en         ID/EX load enable
//   idex_flush      load a bubble into ID/EX
//   exmem_en        EX/MEM load enable
//   memwb_bubble    load a bubble into MEM/WB
//   mem_err         sticky memory timeout flag
//   stall_cycles    saturating count of cycles with pc_en = 0
//
// All hold/flush outputs are combinational from inputs and state so they are
// consumed at the same edge they are produced for.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int unsigned ACK_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      ifid_instr,
   input  logic             idex_memread,
   input  logic [4:0]       idex_rd,
   input  logic             ex_redirect,
   input  logic             exmem_memread,
   input  logic             exmem_memwrite,
   input  logic             dmem_ack,
   output logic             dmem_req,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             memwb_bubble,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ERR  = 2'd2;

   localparam logic [15:0]      TIMEOUT_VAL = 16'(ACK_TIMEOUT);
   localparam logic [15:0]      WAIT_ONE    = 16'd1;
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic [15:0]      wait_cnt_q;
   logic [15:0]      wait_cnt_d;
   logic             mem_err_q;
   logic [CNT_W-1:0] stall_cnt_q;

   logic             mem_op;
   logic             mem_req;
   logic             freeze;
   logic [4:0]       rs1;
   logic [4:0]       rs2;
   logic             load_use;

   // Only the register-specifier fields of the instruction are relevant here.
   logic unused_instr_bits;
   assign unused_instr_bits = ^{ifid_instr[31:25], ifid_instr[14:0]};

   assign mem_op = exmem_memread | exmem_memwrite;
   assign rs1    = ifid_instr[19:15];
   assign rs2    = ifid_instr[24:20];

   // rs1/rs2 are compared regardless of instruction format; an occasional
   // spurious stall is cheaper than decoding the format here.
   assign load_use = idex_memread & (idex_rd != 5'd0) &
                     ((idex_rd == rs1) | (idex_rd == rs2));

   // ---- memory handshake FSM: next state and request/freeze decode ----
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_req    = 1'b0;
      freeze     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_op) begin
               mem_req = 1'b1;
               // A same-cycle ack is a zero-wait access: no freeze at all.
               if (!dmem_ack) begin
                  freeze     = 1'b1;
                  state_d    = ST_WAIT;
                  wait_cnt_d = WAIT_ONE;
               end
            end
         end
         ST_WAIT: begin
            mem_req = 1'b1;
            if (dmem_ack) begin
               // Pipeline advances on this same edge; the next EX/MEM content
               // is sampled fresh in IDLE.
               state_d = ST_IDLE;
            end else begin
               freeze = 1'b1;
               if (wait_cnt_q == TIMEOUT_VAL) begin
                  state_d = ST_ERR;
               end else begin
                  wait_cnt_d = wait_cnt_q + WAIT_ONE;
               end
            end
         end
         ST_ERR: begin
            // Request dropped; pipeline stays frozen until reset.
            freeze = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---- pipeline hold / flush decode ----
   // Priority: reset > freeze > redirect > load-use > default.
   always_comb begin
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      ifid_flush   = 1'b0;
      idex_en      = 1'b1;
      idex_flush   = 1'b0;
      exmem_en     = 1'b1;
      memwb_bubble = 1'b0;
      if (reset) begin
         // keep defaults
      end else if (freeze) begin
         // Redirect/load-use inputs stay valid while EX is held, so they are
         // acted on once the freeze releases.
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         idex_en      = 1'b0;
         exmem_en     = 1'b0;
         memwb_bubble = 1'b1;
      end else if (ex_redirect) begin
         // PC loads the target; the two younger slots are squashed.
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (load_use) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end
   end

   // Reset drops an outstanding request immediately, abandoning the access.
   assign dmem_req     = mem_req & ~reset;
   assign mem_err      = mem_err_q;
   assign stall_cycles = stall_cnt_q;

   // ---- state registers ----
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         wait_cnt_q  <= 16'd0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         if (state_d == ST_ERR) begin
            mem_err_q <= 1'b1;
         end
         if (!pc_en && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl (ACK_TIMEOUT = 4, CNT_W = 4).
// Each cycle the stimulus is driven and the expected control vector is pushed
// to a queue; at the following falling edge the entry is popped and compared.
// Expected vector: {dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
//                   exmem_en, memwb_bubble, mem_err, stall_cycles[3:0]}
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam logic [8:0] NORM    = 9'b011010100;  // all enables, nothing else
   localparam logic [8:0] LU      = 9'b000011100;  // load-use stall
   localparam logic [8:0] REDIR   = 9'b011111100;  // redirect flush
   localparam logic [8:0] FRZ     = 9'b100000010;  // request pending, frozen
   localparam logic [8:0] MEM_OK  = 9'b111010100;  // request acked, flowing
   localparam logic [8:0] ERRV    = 9'b000000011;  // timed out
   localparam logic [8:0] RST_ERR = 9'b011010101;  // reset cycle, flag still set

   logic        clk;
   logic        reset;
   logic [31:0] ifid_instr;
   logic        idex_memread;
   logic [4:0]  idex_rd;
   logic        ex_redirect;
   logic        exmem_memread;
   logic        exmem_memwrite;
   logic        dmem_ack;
   logic        dmem_req;
   logic        pc_en;
   logic        ifid_en;
   logic        ifid_flush;
   logic        idex_en;
   logic        idex_flush;
   logic        exmem_en;
   logic        memwb_bubble;
   logic        mem_err;
   logic [3:0]  stall_cycles;

   logic [12:0] obs;
   logic [12:0] sb[$];
   logic [3:0]  exp_cnt;
   logic        last_pc;
   logic        last_rst;
   int          total;
   int          bad;

   hazard_ctrl #(.ACK_TIMEOUT(4), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .ifid_instr(ifid_instr),
      .idex_memread(idex_memread), .idex_rd(idex_rd), .ex_redirect(ex_redirect),
      .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
      .dmem_ack(dmem_ack), .dmem_req(dmem_req), .pc_en(pc_en), .ifid_en(ifid_en),
      .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
      .exmem_en(exmem_en), .memwb_bubble(memwb_bubble), .mem_err(mem_err),
      .stall_cycles(stall_cycles)
   );

   assign obs = {dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                 exmem_en, memwb_bubble, mem_err, stall_cycles};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [4:0] r1, input logic [4:0] r2);
      return {7'b0, r2, r1, 3'b010, 5'd1, 7'b0000011};
   endfunction

   // Drive one cycle of stimulus and push what the outputs must be.
   task automatic apply(input logic r, input logic [31:0] ins, input logic imr,
                        input logic [4:0] rd, input logic rdr, input logic mr,
                        input logic mw, input logic ack, input logic [8:0] ctl);
      reset          = r;
      ifid_instr     = ins;
      idex_memread   = imr;
      idex_rd        = rd;
      ex_redirect    = rdr;
      exmem_memread  = mr;
      exmem_memwrite = mw;
      dmem_ack       = ack;
      sb.push_back({ctl, exp_cnt});
      last_pc  = ctl[7];
      last_rst = r;
   endtask

   // Advance past the rising edge and update the expected stall count.
   task automatic tick();
      @(posedge clk);
      if (last_rst) exp_cnt = 4'd0;
      else if (!last_pc && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
      #1;
   endtask

   task automatic test_reset();
      logic [12:0] e;
      apply(1, mk(5'd5, 5'd5), 1, 5'd5, 1, 1, 1, 0, NORM);
      void'(sb.pop_front());
      tick();
      for (int i = 0; i < 2; i++) begin
         case (i)
            0: apply(1, mk(5'd5, 5'd5), 1, 5'd5, 1, 1, 1, 0, NORM);
            default: apply(0, mk(5'd1, 5'd2), 0, 5'd0, 0, 0, 0, 0, NORM);
         endcase
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL reset step %0d: got %b required %b", i, obs, e);
         end
         tick();
      end
   endtask

   task automatic test_load_use();
      logic [12:0] e;
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: apply(0, mk(5'd3, 5'd5), 1, 5'd5, 0, 0, 0, 0, LU);
            1: apply(0, mk(5'd3, 5'd5), 0, 5'd0, 0, 0, 0, 0, NORM);
            2: apply(0, mk(5'd7, 5'd9), 1, 5'd7, 0, 0, 0, 0, LU);
            3: apply(0, mk(5'd7, 5'd9), 0, 5'd7, 0, 0, 0, 0, NORM);
            default: apply(0, mk(5'd4, 5'd6), 1, 5'd5, 0, 0, 0, 0, NORM);
         endcase
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL load_use step %0d: got %b required %b", i, obs, e);
         end
         tick();
      end
   endtask

   task automatic test_rd_zero();
      logic [12:0] e;
      for (int i = 0; i < 2; i++) begin
         case (i)
            0: apply(0, mk(5'd0, 5'd0), 1, 5'd0, 0, 0, 0, 0, NORM);
            default: apply(0, mk(5'd0, 5'd3), 1, 5'd0, 0, 0, 0, 0, NORM);
         endcase
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL rd_zero step %0d: got %b required %b", i, obs, e);
         end
         tick();
      end
   endtask

   task automatic test_redirect();
      logic [12:0] e;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: apply(0, mk(5'd8, 5'd2), 1, 5'd8, 1, 0, 0, 0, REDIR);
            1: apply(0, mk(5'd1, 5'd2), 0, 5'd0, 1, 0, 0, 0, REDIR);
            2: apply(0, mk(5'd1, 5'd2), 0, 5'd0, 0, 0, 0, 0, NORM);
            default: apply(0, mk(5'd1, 5'd11), 1, 5'd11, 0, 0, 0, 0, LU);
         endcase
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL redirect step %0d: got %b required %b", i, obs, e);
         end
         tick();
      end
   endtask

   // Ack arrives 3 cycles after the request; redirect and load-use are
   // presented throughout and must only take effect on the release cycle.
   task automatic test_mem_wait();
      logic [12:0] e;
      for (int i = 0; i < 5; i++) begin
         case (i)
            0, 1, 2: apply(0, mk(5'd6, 5'd2), 1, 5'd6, 1, 1, 0, 0, FRZ);
            3: apply(0, mk(5'd6, 5'd2), 1, 5'd6, 1, 1, 0, 1, 9'b111111100);
            default: apply(0, mk(5'd1, 5'd2), 0, 5'd0, 0, 0, 0, 0, NORM);
         endcase
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL mem_wait step %0d: got %b required %b", i, obs, e);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [12:0] e;
      for (int i = 0; i < 8; i++) begin
         case (i)
            0: apply(0, mk(5'd1, 5'd2), 0, 5'd0, 0, 0, 1, 1, MEM_OK);
            1: apply(0, mk(5'd1, 5'd2), 0, 5'd0, 0, 0, 1, 0, FRZ);
            2: apply(0, mk(5'd1, 5'd2), 0, 5'd0, 0, 0, 1, 1, MEM_OK);
            3: apply(0, mk(5'd1, 5'd2), 0, 5'd0, 0, 1, 0, 0, FRZ);
            4: apply(0, mk(5'd1, 5'd2), 0, 5'd0, 0, 1, 0, 1, MEM_OK);
            5: apply(0, mk(5'd1, 5'd2), 0, 5'd0, 0, 0, 0, 1, NORM);
            6: apply(0, mk(5'd9, 5'd2), 1, 5'd9, 0, 0, 0, 0, LU);
            default: apply(0, mk(5'd9, 5'd2), 1, 5'd9, 0, 1, 0, 1, 9'b100011100);
         endcase
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL back_to_back step %0d: got %b required %b", i, obs, e);
         end
         tick();
      end
   endtask

   // ACK_TIMEOUT = 4: five frozen request cycles, then ERR until reset.
   task automatic test_timeout();
      logic [12:0] e;
      for (int i = 0; i < 10; i++) begin
         case (i)
            0, 1, 2, 3, 4: apply(0, mk(5'd1, 5'd2), 0, 5'd0, 0, 1, 0, 0, FRZ);
            5: apply(0, mk(5'd1, 5'd2), 0, 5'd0, 1, 1, 0, 0, ERRV);
            6: apply(0, mk(5'd1, 5'd2), 0, 5'd0, 0, 1, 0, 1, ERRV);
            7: apply(0, mk(5'd1, 5'd2), 0, 5'd0, 0, 0, 0, 0, ERRV);
            8: apply(1, mk(5'd1, 5'd2), 0, 5'd0, 0, 1, 0, 0, RST_ERR);
            default: apply(0, mk(5'd1, 5'd2), 0, 5'd0, 0, 0, 0, 0, NORM);
         endcase
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL timeout step %0d: got %b required %b", i, obs, e);
         end
         tick();
      end
   endtask

   task automatic test_saturation();
      logic [12:0] e;
      for (int i = 0; i < 21; i++) begin
         if (i == 0) apply(1, mk(5'd1, 5'd2), 0, 5'd0, 0, 0, 0, 0, NORM);
         else if (i <= 5) apply(0, mk(5'd1, 5'd2), 0, 5'd0, 0, 1, 0, 0, FRZ);
         else apply(0, mk(5'd1, 5'd2), 0, 5'd0, 0, 1, 0, 0, ERRV);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL saturation step %0d: got %b required %b", i, obs, e);
         end
         tick();
      end
      @(negedge clk);
      total++;
      if (stall_cycles !== 4'd15) begin
         bad++;
         $display("FAIL saturation_final: got %0d required 15", stall_cycles);
      end
      tick();
      for (int i = 0; i < 2; i++) begin
         if (i == 0) apply(1, mk(5'd1, 5'd2), 0, 5'd0, 0, 1, 0, 0, RST_ERR);
         else apply(0, mk(5'd1, 5'd2), 0, 5'd0, 0, 0, 0, 0, NORM);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL saturation_reset step %0d: got %b required %b", i, obs, e);
         end
         tick();
      end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      exp_cnt  = 4'd0;
      last_pc  = 1'b1;
      last_rst = 1'b1;
      test_reset();
      test_load_use();
      test_rd_zero();
      test_redirect();
      test_mem_wait();
      test_back_to_back();
      test_timeout();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline control block for the 5-stage RISC-V core. It reads the hazard-relevant fields held in the IF/ID, ID/EX and EX/MEM buffer registers and returns the hold and flush controls that gate those registers. It covers three cases:
- load-use stalls;
- EX-stage redirect flushes (taken branch or jump);
- a multi-cycle data-memory request/acknowledge handshake with a timeout, which freezes the whole pipeline.

## Interface
- ACK_TIMEOUT, 16: maximum number of WAIT cycles without `dmem_ack` before the block enters ERR; legal range 1..65535.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ifid_instr  in  32  IF/ID Curr_Instr; rs1 = [19:15], rs2 = [24:20].
- idex_memread  in  1  ID/EX MemRead.
- idex_rd  in  5  ID/EX rd.
- ex_redirect  in  1  branch taken or jump resolved in EX this cycle.
- exmem_memread  in  1  EX/MEM MemRead.
- exmem_memwrite  in  1  EX/MEM MemWrite.
- dmem_ack  in  1  data memory has completed the access this cycle.
- dmem_req  out  1  data memory request, held until acknowledged.
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  load a NOP into IF/ID (Curr_Instr = 32'h00000013).
- idex_en  out  1  ID/EX load enable.
- idex_flush  out  1  load a bubble into ID/EX (all control bits 0).
- exmem_en  out  1  EX/MEM load enable.
- memwb_bubble  out  1  load a bubble into MEM/WB (RegWrite = 0).
- mem_err  out  1  sticky timeout flag.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en = 0.

## Operation
Definitions:
- mem_op = exmem_memread | exmem_memwrite.
- freeze = the pipeline is held because a memory access is unacknowledged, or the block is in ERR.

Memory FSM; the state is registered and the outputs are decoded combinationally in the same cycle:
- **IDLE**
  - If mem_op = 0: dmem_req = 0, freeze = 0.
  - If mem_op = 1: dmem_req = 1.
    - With dmem_ack = 1 (zero-wait access): freeze = 0 and the FSM stays in IDLE.
    - With dmem_ack = 0: freeze = 1, the FSM moves to WAIT, and wait_cnt ← 1.
- **WAIT**
  - dmem_req = 1.
  - If dmem_ack = 1: freeze = 0 and the FSM moves to IDLE; the pipeline advances on that same edge.
  - If dmem_ack = 0: freeze = 1.
    - If wait_cnt = ACK_TIMEOUT, the FSM moves to ERR.
    - Otherwise wait_cnt increments.
- **ERR**
  - dmem_req = 0, freeze = 1, mem_err = 1.
  - The FSM leaves ERR only on reset.

While freeze = 1:
- pc_en, ifid_en, idex_en and exmem_en are all 0.
- memwb_bubble = 1.
- Both flushes are 0.
- ex_redirect and load-use are ignored. The inputs stay valid because EX is held, so they are acted on once the freeze releases.

Load-use, evaluated only when freeze = 0:
- Condition: idex_memread & (idex_rd ≠ 0) & ((idex_rd = rs1) | (idex_rd = rs2)).
- rs1 and rs2 are compared unconditionally, whatever the instruction format. A spurious stall is acceptable.
- Response: pc_en = 0, ifid_en = 0, idex_flush = 1. All other enables stay at 1.

Redirect, evaluated only when freeze = 0; it dominates load-use:
- Response: pc_en = 1 (the PC loads the target), ifid_flush = 1, idex_flush = 1.
- The load-use stall is suppressed that cycle.

Default when no condition applies: all enables = 1, both flushes = 0, memwb_bubble = 0.

stall_cycles:
- Increments on each edge where pc_en = 0.
- Saturates at all-ones.

## Timing
- Reset (synchronous):
  - state ← IDLE, wait_cnt ← 0, stall_cycles ← 0, mem_err ← 0.
  - During any cycle with reset = 1, outputs are forced: dmem_req = 0, all enables = 1, both flushes = 0, memwb_bubble = 0.
- Reset asserted in WAIT or ERR returns the FSM to IDLE on the next edge and drops dmem_req immediately; an outstanding access is abandoned.
- All hold and flush outputs are combinational from the inputs and state, with zero-cycle latency. They are consumed at the same edge.
- Load-use costs exactly 1 bubble. A redirect costs 2 flushed slots.
- A memory access with dmem_ack first seen N cycles after the request costs N freeze cycles.
- Back-to-back memory ops: after an acknowledge, the next EX/MEM content is sampled fresh in IDLE, so a new request begins the following cycle.
- dmem_ack while dmem_req = 0 is ignored.
- The ERR transition occurs exactly ACK_TIMEOUT + 1 cycles after the first unacknowledged request cycle.

## Test plan
- **Load-use:** idex_memread = 1, idex_rd = 5, ifid_instr rs2 = 5, no mem_op -> exactly 1 cycle with pc_en = 0, ifid_en = 0, idex_flush = 1; stall_cycles = 1.
- **rd = x0:** idex_rd = 0, rs1 = 0 -> no stall, all enables = 1.
- **Redirect beats load-use:** ex_redirect = 1 together with a load-use match -> pc_en = 1, ifid_flush = 1, idex_flush = 1, stall_cycles unchanged.
- **Wait-state access:** exmem_memread = 1 with dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles; pc_en, ifid_en, idex_en, exmem_en low for 3 cycles; memwb_bubble high for 3; state back in IDLE.
- **Timeout:** ACK_TIMEOUT = 4, mem_op held, no ack -> ERR entered after 5 cycles; mem_err = 1 and dmem_req = 0 from then on, pipeline frozen; reset -> mem_err = 0, enables = 1.
- **Saturation:** CNT_W = 4, 20 consecutive frozen cycles -> stall_cycles = 15.
